// File: rtl/ysyx_22050854_wb_stage.sv
// Writeback stage: formats load data, buffers up to two results in order,
// and drives the register-file write port plus difftest commit information.
module ysyx_22050854_wb_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    input  logic [1:0]      in_load_size,
    input  logic            in_load_unsigned,
    input  logic [2:0]      in_addr_low,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic            commit_stall,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit_valid,
    output logic [63:0]     commit_pc,
    output logic            misalign_err,
    output logic [63:0]     instret
);

    // Two-entry storage; pointers are one bit wide and wrap naturally.
    logic [63:0]     pcMem_q   [2];
    logic [4:0]      rdMem_q   [2];
    logic            wenMem_q  [2];
    logic [XLEN-1:0] dataMem_q [2];
    logic            misMem_q  [2];

    logic            wrPtr_q, wrPtr_d;
    logic            rdPtr_q, rdPtr_d;
    logic [1:0]      count_q, count_d;
    logic [63:0]     instret_q, instret_d;

    logic [XLEN-1:0] byteShift, halfShift, wordShift;
    logic [XLEN-1:0] loadData;
    logic            loadMisalign;
    logic [XLEN-1:0] entryData;
    logic            entryMis;
    logic            entryWen;
    logic            headValid;
    logic            push;
    logic            pop;

    assign headValid = (count_q != 2'd0);
    assign in_ready  = (count_q < 2'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = headValid && !commit_stall;

    // Extract the addressed field from the raw doubleword and extend it;
    // the field offset is the address rounded down to the access size.
    always_comb begin
        byteShift    = in_mem_rdata >> {in_addr_low, 3'b000};
        halfShift    = in_mem_rdata >> {in_addr_low[2:1], 4'b0000};
        wordShift    = in_mem_rdata >> {in_addr_low[2], 5'b00000};
        loadData     = '0;
        loadMisalign = 1'b0;
        case (in_load_size)
            2'd0: begin
                loadData = in_load_unsigned ? {{(XLEN-8){1'b0}}, byteShift[7:0]}
                                            : {{(XLEN-8){byteShift[7]}}, byteShift[7:0]};
            end
            2'd1: begin
                loadData     = in_load_unsigned ? {{(XLEN-16){1'b0}}, halfShift[15:0]}
                                                : {{(XLEN-16){halfShift[15]}}, halfShift[15:0]};
                loadMisalign = in_addr_low[0];
            end
            2'd2: begin
                loadData     = in_load_unsigned ? {{(XLEN-32){1'b0}}, wordShift[31:0]}
                                                : {{(XLEN-32){wordShift[31]}}, wordShift[31:0]};
                loadMisalign = (in_addr_low[1:0] != 2'b00);
            end
            default: begin
                loadData     = in_mem_rdata;
                loadMisalign = (in_addr_low != 3'b000);
            end
        endcase
    end

    // Misalignment only applies to loads; x0 and misaligned loads never write.
    always_comb begin
        entryMis  = in_is_load && loadMisalign;
        entryData = in_is_load ? loadData : in_alu_result;
        entryWen  = in_rd_wen && (in_rd != 5'd0) && !entryMis;
    end

    // Pointer, occupancy and retire-counter bookkeeping for push/pop.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        instret_d = instret_q;
        if (push) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d   = ~rdPtr_q;
            instret_d = instret_q + 64'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Control state; reset discards any buffered entries immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            count_q   <= 2'd0;
            instret_q <= 64'd0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            instret_q <= instret_d;
        end
    end

    // Entry storage written at the write pointer on every accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pcMem_q[i]   <= 64'd0;
                rdMem_q[i]   <= 5'd0;
                wenMem_q[i]  <= 1'b0;
                dataMem_q[i] <= '0;
                misMem_q[i]  <= 1'b0;
            end
        end else if (push) begin
            pcMem_q[wrPtr_q]   <= in_pc;
            rdMem_q[wrPtr_q]   <= in_rd;
            wenMem_q[wrPtr_q]  <= entryWen;
            dataMem_q[wrPtr_q] <= entryData;
            misMem_q[wrPtr_q]  <= entryMis;
        end
    end

    // Head entry drives the write port; contents read as zero when empty.
    always_comb begin
        commit_valid = pop;
        rf_wen       = pop && wenMem_q[rdPtr_q];
        misalign_err = pop && misMem_q[rdPtr_q];
        rf_waddr     = headValid ? rdMem_q[rdPtr_q]   : 5'd0;
        rf_wdata     = headValid ? dataMem_q[rdPtr_q] : '0;
        commit_pc    = headValid ? pcMem_q[rdPtr_q]   : 64'd0;
        instret      = instret_q;
    end

endmodule

// File: tb/tb_ysyx_22050854_wb_stage.sv
// Self-checking bench for the writeback stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ysyx_22050854_wb_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [2:0]  in_addr_low;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_rdata;
    logic        commit_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        misalign_err;
    logic [63:0] instret;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        mis;
    } entry_t;

    entry_t      modelQ[$];
    logic [63:0] modelInstret;
    int          checks;
    int          errors;

    localparam logic [63:0] RDATA = 64'h1122_3344_8566_7788;

    ysyx_22050854_wb_stage dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_rd            (in_rd),
        .in_rd_wen        (in_rd_wen),
        .in_is_load       (in_is_load),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_addr_low      (in_addr_low),
        .in_alu_result    (in_alu_result),
        .in_mem_rdata     (in_mem_rdata),
        .commit_stall     (commit_stall),
        .rf_wen           (rf_wen),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .misalign_err     (misalign_err),
        .instret          (instret)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result for an instruction: the field sits at the address
    // rounded down to the access size, and a nonzero remainder is misaligned.
    function automatic entry_t buildEntry();
        entry_t      e;
        int          nbytes;
        int          off;
        logic [63:0] raw;
        logic [63:0] mask;
        nbytes = 1 << in_load_size;
        off    = int'(in_addr_low) - (int'(in_addr_low) % nbytes);
        e.pc   = in_pc;
        e.rd   = in_rd;
        e.mis  = in_is_load && ((int'(in_addr_low) % nbytes) != 0);
        if (in_is_load) begin
            raw = in_mem_rdata >> (8 * off);
            if (nbytes == 8) begin
                e.data = raw;
            end else begin
                mask   = (64'd1 << (8 * nbytes)) - 64'd1;
                e.data = raw & mask;
                if (!in_load_unsigned && e.data[8*nbytes-1]) e.data = e.data | ~mask;
            end
        end else begin
            e.data = in_alu_result;
        end
        e.wen = in_rd_wen && (in_rd != 5'd0) && !e.mis;
        return e;
    endfunction

    // Compare every output against what the model's head says.
    task automatic checkAll();
        entry_t h;
        logic   expPop;
        h      = '{pc: 64'd0, rd: 5'd0, wen: 1'b0, data: 64'd0, mis: 1'b0};
        if (modelQ.size() > 0) h = modelQ[0];
        expPop = (modelQ.size() > 0) && !commit_stall;
        checkOutput("in_ready", in_ready, 64'(modelQ.size() < 2));
        checkOutput("commit_valid", commit_valid, 64'(expPop));
        checkOutput("rf_wen", rf_wen, 64'(expPop && h.wen));
        checkOutput("misalign_err", misalign_err, 64'(expPop && h.mis));
        checkOutput("rf_waddr", rf_waddr, 64'(h.rd));
        checkOutput("rf_wdata", rf_wdata, h.data);
        checkOutput("commit_pc", commit_pc, h.pc);
        checkOutput("instret", instret, modelInstret);
    endtask

    task automatic waitCheck();
        @(negedge clock);
        checkAll();
    endtask

    // Advance the model across the rising edge using the inputs present there.
    task automatic advance();
        logic   doPop;
        logic   doPush;
        entry_t e;
        @(posedge clock);
        doPop  = (modelQ.size() > 0) && !commit_stall;
        doPush = in_valid && (modelQ.size() < 2);
        e      = buildEntry();
        if (doPop) begin
            void'(modelQ.pop_front());
            modelInstret = modelInstret + 64'd1;
        end
        if (doPush) modelQ.push_back(e);
        #1;
    endtask

    task automatic stepCycle();
        waitCheck();
        advance();
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] pc, input logic [4:0] rd,
                                 input logic rdWen, input logic isLoad, input logic [1:0] size,
                                 input logic uns, input logic [2:0] addr, input logic [63:0] alu,
                                 input logic [63:0] rdata);
        in_valid         = valid;
        in_pc            = pc;
        in_rd            = rd;
        in_rd_wen        = rdWen;
        in_is_load       = isLoad;
        in_load_size     = size;
        in_load_unsigned = uns;
        in_addr_low      = addr;
        in_alu_result    = alu;
        in_mem_rdata     = rdata;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 64'd0);
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        checks       = 0;
        errors       = 0;
        modelInstret = 64'd0;
        commit_stall = 1'b0;
        reset        = 1'b1;
        idle();
        #12;
        checkOutput("reset_in_ready", in_ready, 64'd1);
        checkOutput("reset_rf_wen", rf_wen, 64'd0);
        checkOutput("reset_instret", instret, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // lb from byte 3, sign-extended
        applyStimulus(1'b1, 64'h100, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 64'd0, RDATA);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("lb_wen", rf_wen, 64'd1);
        checkOutput("lb_waddr", rf_waddr, 64'd5);
        checkOutput("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF85);
        advance();
        checkOutput("lb_instret", instret, 64'd1);

        // lhu and lw from offset 4
        applyStimulus(1'b1, 64'h104, 5'd6, 1'b1, 1'b1, 2'd1, 1'b1, 3'd4, 64'd0, RDATA);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("lhu_wdata", rf_wdata, 64'h0000_0000_0000_3344);
        advance();
        applyStimulus(1'b1, 64'h108, 5'd7, 1'b1, 1'b1, 2'd2, 1'b0, 3'd4, 64'd0, RDATA);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("lw_wdata", rf_wdata, 64'h0000_0000_1122_3344);
        advance();

        // Non-load to x0 retires without writing
        applyStimulus(1'b1, 64'h10C, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hDEAD, 64'd0);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("x0_commit_valid", commit_valid, 64'd1);
        checkOutput("x0_rf_wen", rf_wen, 64'd0);
        advance();
        checkOutput("x0_instret", instret, 64'd4);

        // Misaligned lw
        applyStimulus(1'b1, 64'h200, 5'd8, 1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 64'd0, RDATA);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("mis_err", misalign_err, 64'd1);
        checkOutput("mis_rf_wen", rf_wen, 64'd0);
        checkOutput("mis_commit_valid", commit_valid, 64'd1);
        checkOutput("mis_commit_pc", commit_pc, 64'h200);
        advance();

        // Stall fills the buffer; C is refused until space frees up
        commit_stall = 1'b1;
        applyStimulus(1'b1, 64'h300, 5'd10, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hA, 64'd0);
        stepCycle();
        applyStimulus(1'b1, 64'h304, 5'd11, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hB, 64'd0);
        stepCycle();
        applyStimulus(1'b1, 64'h308, 5'd12, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hC, 64'd0);
        waitCheck();
        checkOutput("full_in_ready", in_ready, 64'd0);
        checkOutput("stall_rf_wen", rf_wen, 64'd0);
        advance();
        commit_stall = 1'b0;
        waitCheck();
        checkOutput("order_a_waddr", rf_waddr, 64'd10);
        checkOutput("order_a_wen", rf_wen, 64'd1);
        advance();
        waitCheck();
        checkOutput("order_b_waddr", rf_waddr, 64'd11);
        checkOutput("order_b_ready", in_ready, 64'd1);
        advance();
        idle();
        waitCheck();
        checkOutput("order_c_wdata", rf_wdata, 64'hC);
        advance();

        // Reset while two entries are buffered
        commit_stall = 1'b1;
        applyStimulus(1'b1, 64'h400, 5'd13, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'h11, 64'd0);
        stepCycle();
        stepCycle();
        idle();
        #2;
        reset = 1'b1;
        #1;
        modelQ.delete();
        modelInstret = 64'd0;
        checkOutput("rst_rf_wen", rf_wen, 64'd0);
        checkOutput("rst_commit_valid", commit_valid, 64'd0);
        checkOutput("rst_in_ready", in_ready, 64'd1);
        checkOutput("rst_instret", instret, 64'd0);
        checkOutput("rst_wdata", rf_wdata, 64'd0);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        commit_stall = 1'b0;
        applyStimulus(1'b1, 64'h500, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'h1234, 64'd0);
        stepCycle();
        idle();
        waitCheck();
        checkOutput("post_rst_wen", rf_wen, 64'd1);
        checkOutput("post_rst_waddr", rf_waddr, 64'd3);
        advance();

        // Randomized traffic with stall bursts
        for (int i = 0; i < 400; i++) begin
            logic       ld;
            logic [1:0] sz;
            ld = ($urandom_range(0, 1) == 1);
            sz = ld ? 2'($urandom_range(0, 3)) : 2'd0;
            applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3) != 0, ld, sz, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
            commit_stall = (i % 50 < 8) ? 1'b1 : ($urandom_range(0, 9) < 3);
            stepCycle();
        end
        idle();
        commit_stall = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
